// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for pipeline_hazard_unit and its helpers.
//   - hz_state_e  : externally visible interlock state (RUN/DSTALL/CSTALL/HALT)
//   - FWD_REGFILE : forward-select value meaning "take the register file"
//   - sb_entry_t  : one scoreboard slot {valid, addr, load}
//   The scoreboard address field is SB_AW bits wide so the struct can live in
//   a non-parameterised package; register addresses (REG_AW <= SB_AW) are
//   zero-extended into it.
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      HZ_RUN    = 2'd0,
      HZ_DSTALL = 2'd1,
      HZ_CSTALL = 2'd2,
      HZ_HALT   = 2'd3
   } hz_state_e;

   localparam int FWD_REGFILE = 0;

   // Widest register address the scoreboard can hold.
   localparam int SB_AW = 8;

   // Bubble counter width; covers BR_BUBBLES in 0..7.
   localparam int BCNT_W = 3;

   typedef struct packed {
      logic             valid;
      logic [SB_AW-1:0] addr;
      logic             load;
   } sb_entry_t;

endpackage

// File: rtl/debug_step_gen.sv
// -----------------------------------------------------------------------------
// debug_step_gen
//   Generates the global pipeline enable. With debug_en=0 the pipeline runs.
//   With debug_en=1 it is halted, except for exactly one cycle following each
//   rising edge of debug_step. cpu_en is registered, so it reacts one cycle
//   after debug_en/debug_step change; it comes out of reset as 1.
//   The step edge-detect flop keeps sampling even while halted, otherwise a
//   step request could never be seen.
// Ports
//   clk        in  clock, rising edge
//   rst        in  synchronous active-low reset
//   debug_en   in  1 = halt unless stepped
//   debug_step in  step request (rising edge = one cycle)
//   cpu_en     out global pipeline enable
// -----------------------------------------------------------------------------
module debug_step_gen (
   input  logic clk,
   input  logic rst,
   input  logic debug_en,
   input  logic debug_step,
   output logic cpu_en
);

   logic step_q, step_d;
   logic cpu_en_q, cpu_en_d;

   always_comb begin
      step_d   = debug_step;
      cpu_en_d = !debug_en || (debug_step && !step_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         step_q   <= 1'b0;
         cpu_en_q <= 1'b1;
      end else begin
         step_q   <= step_d;
         cpu_en_q <= cpu_en_d;
      end
   end

   assign cpu_en = cpu_en_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit
//   Hazard/interlock unit for the MIPS pipeline, sitting beside ID.
//   A scoreboard of PIPE_DEPTH entries tracks in-flight register writers
//   (entry 1 = EXE, 2 = MEM, ...). From it the unit derives:
//     - data stalls (PC/IF-ID hold, ID/EX bubble), combinational in the
//       same cycle the hazard appears in ID;
//     - forwarding selects (lowest matching stage wins);
//     - control-transfer fetch bubbles (BR_BUBBLES cycles of IF/ID flush);
//     - the debug halt/single-step enable (via debug_step_gen).
//   Priority of reported state: HALT > DSTALL > CSTALL > RUN.
//   cpu_en=0 freezes every internal register; outputs hold because ID is
//   frozen too.
//   Build option FORWARD_EN:
//     defined   - forwarding selects active, interlock only on load-use
//                 (matching load in stage 1);
//     undefined - selects tied to the register file, interlock on any match
//                 until the writer leaves the scoreboard.
// Ports
//   clk, rst                    clock / synchronous active-low reset
//   debug_en, debug_step        debug halt and single-step request
//   id_valid .. id_ctrl_xfer    decoded fields of the instruction in ID
//   cpu_en                      global pipeline enable
//   pc_en, ifid_en              PC and IF/ID register enables
//   ifid_flush, idex_bubble     load NOP into IF/ID / ID/EX
//   fwd_sel_a, fwd_sel_b        0 = regfile, k = stage k result
//   hz_state                    RUN=0 DSTALL=1 CSTALL=2 HALT=3
//   stall_cnt                   saturating count of enabled cycles with pc_en=0
// -----------------------------------------------------------------------------
module pipeline_hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int PIPE_DEPTH = 2,
   parameter int BR_BUBBLES = 1,
   parameter int FWD_W      = 3,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              debug_en,
   input  logic              debug_step,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_we,
   input  logic              id_is_load,
   input  logic              id_ctrl_xfer,
   output logic              cpu_en,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic [FWD_W-1:0]  fwd_sel_a,
   output logic [FWD_W-1:0]  fwd_sel_b,
   output logic [1:0]        hz_state,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic cpu_en_w;

   debug_step_gen u_debug_step_gen (
      .clk        (clk),
      .rst        (rst),
      .debug_en   (debug_en),
      .debug_step (debug_step),
      .cpu_en     (cpu_en_w)
   );

   assign cpu_en = cpu_en_w;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   sb_entry_t          sb_q [PIPE_DEPTH:1];
   sb_entry_t          sb_d [PIPE_DEPTH:1];
   logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic [SB_AW-1:0]   rs_ext, rt_ext, dst_ext;

   assign rs_ext  = SB_AW'(id_rs);
   assign rt_ext  = SB_AW'(id_rt);
   assign dst_ext = SB_AW'(id_dst);

   // ---------------------------------------------------------------------------
   // Source match: scan from the deepest stage up so the lowest k is the
   // value left standing.
   // ---------------------------------------------------------------------------
   logic             hit_a, hit_b;
   logic [FWD_W-1:0] k_a, k_b;
   logic             load_a, load_b;

   always_comb begin
      hit_a  = 1'b0;
      hit_b  = 1'b0;
      k_a    = FWD_W'(FWD_REGFILE);
      k_b    = FWD_W'(FWD_REGFILE);
      load_a = 1'b0;
      load_b = 1'b0;
      for (int k = PIPE_DEPTH; k >= 1; k--) begin
         if (id_use_rs && (id_rs != '0) && sb_q[k].valid && (sb_q[k].addr == rs_ext)) begin
            hit_a  = 1'b1;
            k_a    = FWD_W'(k);
            load_a = sb_q[k].load;
         end
         if (id_use_rt && (id_rt != '0) && sb_q[k].valid && (sb_q[k].addr == rt_ext)) begin
            hit_b  = 1'b1;
            k_b    = FWD_W'(k);
            load_b = sb_q[k].load;
         end
      end
   end

   logic dhaz;

`ifdef FORWARD_EN
   // Only a load still in EXE cannot be forwarded in time.
   assign dhaz = id_valid &&
                 ((hit_a && (k_a == FWD_W'(1)) && load_a) ||
                  (hit_b && (k_b == FWD_W'(1)) && load_b));
   assign fwd_sel_a = k_a;
   assign fwd_sel_b = k_b;
`else
   assign dhaz      = id_valid && (hit_a || hit_b);
   assign fwd_sel_a = FWD_W'(FWD_REGFILE);
   assign fwd_sel_b = FWD_W'(FWD_REGFILE);

   logic unused_fwd;
   assign unused_fwd = ^{k_a, k_b, load_a, load_b};
`endif

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 1; k <= PIPE_DEPTH; k++) begin
            sb_q[k] <= '0;
         end
         bcnt_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         sb_q        <= sb_d;
         bcnt_q      <= bcnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   always_comb begin
      sb_d        = sb_q;
      bcnt_d      = bcnt_q;
      stall_cnt_d = stall_cnt_q;
      if (cpu_en_w) begin
         for (int k = PIPE_DEPTH; k >= 2; k--) begin
            sb_d[k] = sb_q[k-1];
         end
         // A stalled ID sends a bubble down; otherwise the issuing
         // instruction's writer (if any; $0 is never tracked) enters stage 1.
         if (dhaz) begin
            sb_d[1] = '0;
         end else begin
            sb_d[1].valid = id_valid && id_we && (id_dst != '0);
            sb_d[1].addr  = dst_ext;
            sb_d[1].load  = id_is_load;
         end

         // The counter only loads once the control transfer actually issues.
         if (!dhaz) begin
            if (id_valid && id_ctrl_xfer && (BR_BUBBLES != 0)) begin
               bcnt_d = BCNT_W'(BR_BUBBLES);
            end else if (bcnt_q != '0) begin
               bcnt_d = bcnt_q - BCNT_W'(1);
            end
         end

         if (dhaz && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   hz_state_e hz_c;

   always_comb begin
      hz_c        = HZ_RUN;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (dhaz) begin
         hz_c        = HZ_DSTALL;
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end else if (bcnt_q != '0) begin
         hz_c       = HZ_CSTALL;
         ifid_flush = 1'b1;
      end
      if (!cpu_en_w) begin
         hz_c = HZ_HALT;
      end
   end

   assign hz_state  = hz_c;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;
   import hazard_pkg::*;

   localparam int REG_AW     = 5;
   localparam int PIPE_DEPTH = 2;
   localparam int BR_BUBBLES = 3;
   localparam int FWD_W      = 3;
   localparam int CNT_W      = 4;

`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // Hand-derived expectations for the two build flavours.
   localparam int EXP_RAW_STALLS  = FWD ? 0 : 2;
   localparam int EXP_RAW_SEL_A   = FWD ? 1 : 0;
   localparam int EXP_LU_STALLS   = FWD ? 1 : 2;
   localparam int EXP_LU_SEL      = FWD ? 2 : 0;
   localparam int EXP_DBG_SEL_A   = FWD ? 2 : 0;
   localparam int EXP_DBG_SEL_B   = FWD ? 1 : 0;
   localparam bit EXP_DBG_PC_EN   = FWD ? 1'b1 : 1'b0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              debug_en = 1'b0;
   logic              debug_step = 1'b0;
   logic              id_valid = 1'b0;
   logic [REG_AW-1:0] id_rs = '0;
   logic [REG_AW-1:0] id_rt = '0;
   logic              id_use_rs = 1'b0;
   logic              id_use_rt = 1'b0;
   logic [REG_AW-1:0] id_dst = '0;
   logic              id_we = 1'b0;
   logic              id_is_load = 1'b0;
   logic              id_ctrl_xfer = 1'b0;
   logic              cpu_en, pc_en, ifid_en, ifid_flush, idex_bubble;
   logic [FWD_W-1:0]  fwd_sel_a, fwd_sel_b;
   logic [1:0]        hz_state;
   logic [CNT_W-1:0]  stall_cnt;

   int vectors = 0;
   int miscompares = 0;

   pipeline_hazard_unit #(
      .REG_AW     (REG_AW),
      .PIPE_DEPTH (PIPE_DEPTH),
      .BR_BUBBLES (BR_BUBBLES),
      .FWD_W      (FWD_W),
      .CNT_W      (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .debug_en     (debug_en),
      .debug_step   (debug_step),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_dst       (id_dst),
      .id_we        (id_we),
      .id_is_load   (id_is_load),
      .id_ctrl_xfer (id_ctrl_xfer),
      .cpu_en       (cpu_en),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .ifid_flush   (ifid_flush),
      .idex_bubble  (idex_bubble),
      .fwd_sel_a    (fwd_sel_a),
      .fwd_sel_b    (fwd_sel_b),
      .hz_state     (hz_state),
      .stall_cnt    (stall_cnt)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled on
   // the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                         input logic urs, input logic urt, input logic [REG_AW-1:0] dst,
                         input logic we, input logic ld, input logic cx);
      id_valid     = v;
      id_rs        = rs;
      id_rt        = rt;
      id_use_rs    = urs;
      id_use_rt    = urt;
      id_dst       = dst;
      id_we        = we;
      id_is_load   = ld;
      id_ctrl_xfer = cx;
   endtask

   task automatic set_idle();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst        = 1'b0;
      debug_en   = 1'b0;
      debug_step = 1'b0;
      set_idle();
      step();
      rst = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      // debug_en is high through reset: cpu_en must still come out as 1.
      rst      = 1'b0;
      debug_en = 1'b1;
      set_idle();
      step();
      rst = 1'b1;
      @(negedge clk);
      vectors++; if (cpu_en !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_en: got %b want 1", cpu_en); end
      vectors++; if (pc_en !== 1'b1) begin miscompares++; $display("FAIL reset_pc_en: got %b want 1", pc_en); end
      vectors++; if (ifid_en !== 1'b1) begin miscompares++; $display("FAIL reset_ifid_en: got %b want 1", ifid_en); end
      vectors++; if (ifid_flush !== 1'b0) begin miscompares++; $display("FAIL reset_ifid_flush: got %b want 0", ifid_flush); end
      vectors++; if (idex_bubble !== 1'b0) begin miscompares++; $display("FAIL reset_idex_bubble: got %b want 0", idex_bubble); end
      vectors++; if (fwd_sel_a !== 3'd0 || fwd_sel_b !== 3'd0) begin miscompares++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", fwd_sel_a, fwd_sel_b); end
      vectors++; if (hz_state !== 2'd0) begin miscompares++; $display("FAIL reset_hz_state: got %0d want 0", hz_state); end
      vectors++; if (stall_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
      step();
      @(negedge clk);
      vectors++; if (cpu_en !== 1'b0) begin miscompares++; $display("FAIL reset_then_halt_cpu_en: got %b want 0", cpu_en); end
      vectors++; if (hz_state !== 2'd3) begin miscompares++; $display("FAIL reset_then_halt_hz: got %0d want 3", hz_state); end
      debug_en = 1'b0;
      step();
   endtask

   // add $3,$1,$2 ; add $4,$3,$1
   task automatic test_raw_alu();
      int n;
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
      step();
      set_id(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      vectors++; if (fwd_sel_a !== 3'(EXP_RAW_SEL_A)) begin miscompares++; $display("FAIL raw_fwd_sel_a: got %0d want %0d", fwd_sel_a, EXP_RAW_SEL_A); end
      vectors++; if (fwd_sel_b !== 3'd0) begin miscompares++; $display("FAIL raw_fwd_sel_b: got %0d want 0", fwd_sel_b); end
      n = 0;
      while (pc_en === 1'b0 && n < 10) begin
         vectors++; if (hz_state !== 2'd1 || idex_bubble !== 1'b1 || ifid_en !== 1'b0) begin miscompares++; $display("FAIL raw_stall_ctrl: got hz=%0d bub=%b ifid_en=%b want 1/1/0", hz_state, idex_bubble, ifid_en); end
         n++;
         step();
         @(negedge clk);
      end
      vectors++; if (n !== EXP_RAW_STALLS) begin miscompares++; $display("FAIL raw_stall_cycles: got %0d want %0d", n, EXP_RAW_STALLS); end
      vectors++; if (hz_state !== 2'd0) begin miscompares++; $display("FAIL raw_issue_hz: got %0d want 0", hz_state); end
      step();
      set_idle();
      @(negedge clk);
      vectors++; if (stall_cnt !== 4'(EXP_RAW_STALLS)) begin miscompares++; $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, EXP_RAW_STALLS); end
   endtask

   // lw $5,0($1) ; sub $6,$5,$5
   task automatic test_load_use();
      int n;
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      vectors++; if (hz_state !== 2'd1 || pc_en !== 1'b0) begin miscompares++; $display("FAIL lu_first_cycle: got hz=%0d pc_en=%b want 1/0", hz_state, pc_en); end
      n = 0;
      while (pc_en === 1'b0 && n < 10) begin
         n++;
         step();
         @(negedge clk);
      end
      vectors++; if (n !== EXP_LU_STALLS) begin miscompares++; $display("FAIL lu_stall_cycles: got %0d want %0d", n, EXP_LU_STALLS); end
      vectors++; if (fwd_sel_a !== 3'(EXP_LU_SEL)) begin miscompares++; $display("FAIL lu_fwd_sel_a: got %0d want %0d", fwd_sel_a, EXP_LU_SEL); end
      vectors++; if (fwd_sel_b !== 3'(EXP_LU_SEL)) begin miscompares++; $display("FAIL lu_fwd_sel_b: got %0d want %0d", fwd_sel_b, EXP_LU_SEL); end
      step();
      set_idle();
      @(negedge clk);
      vectors++; if (stall_cnt !== 4'(EXP_LU_STALLS)) begin miscompares++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, EXP_LU_STALLS); end
   endtask

   // addi $0,$1,5 ; add $2,$0,$0
   task automatic test_zero_reg();
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      step();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      vectors++; if (pc_en !== 1'b1 || hz_state !== 2'd0) begin miscompares++; $display("FAIL zero_no_stall: got pc_en=%b hz=%0d want 1/0", pc_en, hz_state); end
      vectors++; if (fwd_sel_a !== 3'd0 || fwd_sel_b !== 3'd0) begin miscompares++; $display("FAIL zero_fwd: got %0d/%0d want 0/0", fwd_sel_a, fwd_sel_b); end
      step();
      set_idle();
   endtask

   // beq $1,$2 with BR_BUBBLES=3
   task automatic test_branch();
      int n;
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      vectors++; if (ifid_flush !== 1'b0 || hz_state !== 2'd0) begin miscompares++; $display("FAIL br_issue: got flush=%b hz=%0d want 0/0", ifid_flush, hz_state); end
      step();
      set_idle();
      @(negedge clk);
      vectors++; if (hz_state !== 2'd2 || pc_en !== 1'b1) begin miscompares++; $display("FAIL br_cstall: got hz=%0d pc_en=%b want 2/1", hz_state, pc_en); end
      n = 0;
      while (ifid_flush === 1'b1 && n < 10) begin
         n++;
         step();
         @(negedge clk);
      end
      vectors++; if (n !== BR_BUBBLES) begin miscompares++; $display("FAIL br_flush_cycles: got %0d want %0d", n, BR_BUBBLES); end
      vectors++; if (hz_state !== 2'd0) begin miscompares++; $display("FAIL br_back_to_run: got %0d want 0", hz_state); end
   endtask

   // lw $9 ; beq $9,$0 -- the counter must wait for the beq to issue
   task automatic test_branch_under_stall();
      int n;
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      n = 0;
      while (pc_en === 1'b0 && n < 10) begin
         vectors++; if (ifid_flush !== 1'b0) begin miscompares++; $display("FAIL brst_flush_in_stall: got %b want 0", ifid_flush); end
         n++;
         step();
         @(negedge clk);
      end
      vectors++; if (n !== EXP_LU_STALLS) begin miscompares++; $display("FAIL brst_stall_cycles: got %0d want %0d", n, EXP_LU_STALLS); end
      vectors++; if (ifid_flush !== 1'b0 || hz_state !== 2'd0) begin miscompares++; $display("FAIL brst_issue: got flush=%b hz=%0d want 0/0", ifid_flush, hz_state); end
      step();
      set_idle();
      @(negedge clk);
      n = 0;
      while (ifid_flush === 1'b1 && n < 10) begin
         n++;
         step();
         @(negedge clk);
      end
      vectors++; if (n !== BR_BUBBLES) begin miscompares++; $display("FAIL brst_flush_cycles: got %0d want %0d", n, BR_BUBBLES); end
   endtask

   // Two single steps while halted: writer $7, then writer $8, then a reader
   // of both observed while still frozen.
   task automatic test_debug_step();
      int highs;
      do_reset();
      debug_en = 1'b1;
      step();
      highs = 0;
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      debug_step = 1'b1;
      @(negedge clk); if (cpu_en === 1'b1) highs++;
      step();
      debug_step = 1'b0;
      @(negedge clk); if (cpu_en === 1'b1) highs++;
      step();
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      debug_step = 1'b1;
      @(negedge clk); if (cpu_en === 1'b1) highs++;
      step();
      debug_step = 1'b0;
      @(negedge clk); if (cpu_en === 1'b1) highs++;
      step();
      set_id(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); if (cpu_en === 1'b1) highs++;
         step();
      end
      @(negedge clk);
      vectors++; if (highs !== 2) begin miscompares++; $display("FAIL dbg_step_cycles: got %0d want 2", highs); end
      vectors++; if (hz_state !== 2'd3) begin miscompares++; $display("FAIL dbg_halt_hz: got %0d want 3", hz_state); end
      vectors++; if (fwd_sel_a !== 3'(EXP_DBG_SEL_A)) begin miscompares++; $display("FAIL dbg_sb_sel_a: got %0d want %0d", fwd_sel_a, EXP_DBG_SEL_A); end
      vectors++; if (fwd_sel_b !== 3'(EXP_DBG_SEL_B)) begin miscompares++; $display("FAIL dbg_sb_sel_b: got %0d want %0d", fwd_sel_b, EXP_DBG_SEL_B); end
      vectors++; if (pc_en !== EXP_DBG_PC_EN) begin miscompares++; $display("FAIL dbg_sb_pc_en: got %b want %b", pc_en, EXP_DBG_PC_EN); end
      vectors++; if (stall_cnt !== 4'd0) begin miscompares++; $display("FAIL dbg_frozen_stall_cnt: got %0d want 0", stall_cnt); end
      set_idle();
      debug_en = 1'b0;
      step();
      @(negedge clk);
      vectors++; if (cpu_en !== 1'b1) begin miscompares++; $display("FAIL dbg_release_cpu_en: got %b want 1", cpu_en); end
      step();
   endtask

   // Reset asserted during a data stall.
   task automatic test_reset_mid_stall();
      int n;
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      n = 0;
      while (pc_en === 1'b0 && n < 10) begin
         n++;
         step();
         @(negedge clk);
      end
      step();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      vectors++; if (hz_state !== 2'd1) begin miscompares++; $display("FAIL rst6_in_stall: got %0d want 1", hz_state); end
      vectors++; if (stall_cnt !== 4'(EXP_LU_STALLS)) begin miscompares++; $display("FAIL rst6_pre_cnt: got %0d want %0d", stall_cnt, EXP_LU_STALLS); end
      rst = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      vectors++; if (cpu_en !== 1'b1 || pc_en !== 1'b1 || ifid_en !== 1'b1) begin miscompares++; $display("FAIL rst6_enables: got cpu=%b pc=%b ifid=%b want 1/1/1", cpu_en, pc_en, ifid_en); end
      vectors++; if (ifid_flush !== 1'b0 || idex_bubble !== 1'b0) begin miscompares++; $display("FAIL rst6_nops: got flush=%b bub=%b want 0/0", ifid_flush, idex_bubble); end
      vectors++; if (fwd_sel_a !== 3'd0 || fwd_sel_b !== 3'd0) begin miscompares++; $display("FAIL rst6_fwd: got %0d/%0d want 0/0", fwd_sel_a, fwd_sel_b); end
      vectors++; if (hz_state !== 2'd0) begin miscompares++; $display("FAIL rst6_hz: got %0d want 0", hz_state); end
      vectors++; if (stall_cnt !== 4'd0) begin miscompares++; $display("FAIL rst6_stall_cnt: got %0d want 0", stall_cnt); end
      set_idle();
      step();
   endtask

   // Twenty load-use pairs overflow a 4-bit counter; it must stick at 15.
   task automatic test_stall_cnt_saturate();
      int n;
      int total;
      do_reset();
      total = 0;
      for (int i = 0; i < 20; i++) begin
         set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
         step();
         set_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
         @(negedge clk);
         n = 0;
         while (pc_en === 1'b0 && n < 10) begin
            n++;
            step();
            @(negedge clk);
         end
         total += n;
         step();
      end
      set_idle();
      @(negedge clk);
      vectors++; if (total !== 20 * EXP_LU_STALLS) begin miscompares++; $display("FAIL sat_total_stalls: got %0d want %0d", total, 20 * EXP_LU_STALLS); end
      vectors++; if (stall_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_stall_cnt: got %0d want 15", stall_cnt); end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      step();
      test_reset();
      test_raw_alu();
      test_load_use();
      test_zero_reg();
      test_branch();
      test_branch_under_stall();
      test_debug_step();
      test_reset_mid_stall();
      test_stall_cnt_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
